// File: rtl/time_entry_loader_if.sv
// time_entry_loader_if: keypad, control and counter-load bundle
// master = keypad/timer side, slave = time_entry_loader
interface time_entry_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       cancel;
  logic       timer_zero;
  logic       loadn;
  logic       load_enable;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       entry_active;
  logic       entry_error;

  modport master (
    output key_valid, key_code, start, cancel, timer_zero,
    input  loadn, load_enable, min_tens, min_ones,
    input  sec_tens, sec_ones, entry_active, entry_error
  );

  modport slave (
    input  key_valid, key_code, start, cancel, timer_zero,
    output loadn, load_enable, min_tens, min_ones,
    output sec_tens, sec_ones, entry_active, entry_error
  );
endinterface

// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad MM:SS entry and one-cycle counter load
// Optional macro TIME_ENTRY_NORMALIZE_EN: fold seconds >= 60 into minutes
module time_entry_loader #(
  parameter logic [3:0] SEC_TENS_MAX = 4'd5
) (
  input logic            clock,
  input logic            clear,
  time_entry_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD,
    HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_d;
  logic       loadn_q, len_q, act_q, err_q;

  logic is_digit;
  logic all_zero;
  logic sec_over;

  assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign all_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0);
  assign sec_over = (st_q > SEC_TENS_MAX);

  // next-state, digit shift, start validation and normalisation
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (bus.cancel) begin
          {mt_d, mo_d, st_d, so_d} = 16'h0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else if (bus.start) begin
          if (state_q == ENTRY && !all_zero) begin
`ifdef TIME_ENTRY_NORMALIZE_EN
            if (sec_over) begin
              if (mt_q == 4'd9 && mo_q == 4'd9) begin
                err_d = 1'b1;
              end else begin
                st_d = st_q - 4'd6;
                if (mo_q == 4'd9) begin
                  mo_d = 4'd0;
                  mt_d = mt_q + 4'd1;
                end else begin
                  mo_d = mo_q + 4'd1;
                end
                state_d = LOAD;
              end
            end else begin
              state_d = LOAD;
            end
`else
            if (sec_over) begin
              err_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
`endif
          end
        end else if (is_digit && cnt_q < 3'd4) begin
          mt_d    = mo_q;
          mo_d    = st_q;
          st_d    = so_q;
          so_d    = bus.key_code;
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
      end
      LOAD: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.timer_zero || bus.cancel) begin
          {mt_d, mo_d, st_d, so_d} = 16'h0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, digits and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      {mt_q, mo_q, st_q, so_q} <= 16'h0;
      cnt_q   <= 3'd0;
      loadn_q <= 1'b1;
      len_q   <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      loadn_q <= (state_d != LOAD);
      len_q   <= (state_d == LOAD);
      act_q   <= (state_d == ENTRY);
      err_q   <= err_d;
    end
  end

  assign bus.loadn        = loadn_q;
  assign bus.load_enable  = len_q;
  assign bus.entry_active = act_q;
  assign bus.entry_error  = err_q;
  assign bus.min_tens     = mt_q;
  assign bus.min_ones     = mo_q;
  assign bus.sec_tens     = st_q;
  assign bus.sec_ones     = so_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// tb_time_entry_loader: directed table plus randomized model check
// Output word compared each cycle: {loadn, load_enable, entry_active, entry_error, digits}
module tb_time_entry_loader;

  localparam int SEC_TENS_MAX = 5;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;

  time_entry_loader_if bus();

  time_entry_loader dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        clr;
    bit        kv;
    bit [3:0]  kc;
    bit        st;
    bit        ca;
    bit        tz;
    bit [19:0] exp;
  } row_t;

  row_t vec[$];

  function automatic row_t mk(bit clr, bit kv, bit [3:0] kc, bit st,
                              bit ca, bit tz, bit ln, bit le, bit ea,
                              bit er, bit [15:0] dg);
    row_t r;
    r.clr = clr; r.kv = kv; r.kc = kc;
    r.st = st; r.ca = ca; r.tz = tz;
    r.exp = {ln, le, ea, er, dg};
    return r;
  endfunction

  function automatic bit [19:0] observed();
    return {bus.loadn, bus.load_enable, bus.entry_active,
            bus.entry_error, bus.min_tens, bus.min_ones,
            bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic drive(bit clr, bit kv, bit [3:0] kc, bit st,
                       bit ca, bit tz);
    clear          = clr;
    bus.key_valid  = kv;
    bus.key_code   = kc;
    bus.start      = st;
    bus.cancel     = ca;
    bus.timer_zero = tz;
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, bit [19:0] act, bit [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // reference model: the entered time as a 4-digit decimal number
  int v, cnt;
  bit m_entry, m_load, m_hold, m_err;

  function automatic bit [15:0] to_bcd(int x);
    return {4'(x / 1000), 4'((x / 100) % 10),
            4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic model(bit clr, bit kv, bit [3:0] kc, bit st,
                       bit ca, bit tz);
    int mins, secs;
    m_err = 0;
    if (clr) begin
      v = 0; cnt = 0; m_entry = 0; m_load = 0; m_hold = 0;
    end else if (m_load) begin
      m_load = 0; m_hold = 1;
    end else if (m_hold) begin
      if (tz || ca) begin
        m_hold = 0; v = 0; cnt = 0;
      end
    end else if (ca) begin
      v = 0; cnt = 0; m_entry = 0;
    end else if (st) begin
      if (m_entry && v != 0) begin
        mins = v / 100;
        secs = v % 100;
`ifdef TIME_ENTRY_NORMALIZE_EN
        if (secs >= 60) begin
          if (mins == 99) m_err = 1;
          else begin
            v = (mins + 1) * 100 + secs - 60;
            m_load = 1; m_entry = 0;
          end
        end else begin
          m_load = 1; m_entry = 0;
        end
`else
        if (secs / 10 > SEC_TENS_MAX) m_err = 1;
        else begin
          m_load = 1; m_entry = 0;
        end
`endif
      end
    end else if (kv && kc <= 9 && cnt < 4) begin
      v = (v * 10 + int'(kc)) % 10000;
      cnt++;
      m_entry = 1;
    end
  endtask

  function automatic bit [19:0] model_out();
    return {~m_load, m_load, m_entry, m_err, to_bcd(v)};
  endfunction

  initial begin
    // reset and 01:30 load then timer_zero exit
    vec.push_back(mk(1,0,0,0,0,0, 1,0,0,0,16'h0000));
    vec.push_back(mk(0,1,1,0,0,0, 1,0,1,0,16'h0001));
    vec.push_back(mk(0,1,3,0,0,0, 1,0,1,0,16'h0013));
    vec.push_back(mk(0,1,0,0,0,0, 1,0,1,0,16'h0130));
    vec.push_back(mk(0,0,0,1,0,0, 0,1,0,0,16'h0130));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0130));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0130));
    vec.push_back(mk(0,0,0,0,0,1, 1,0,0,0,16'h0000));
    // 00:90 start
    vec.push_back(mk(0,1,9,0,0,0, 1,0,1,0,16'h0009));
    vec.push_back(mk(0,1,0,0,0,0, 1,0,1,0,16'h0090));
`ifdef TIME_ENTRY_NORMALIZE_EN
    vec.push_back(mk(0,0,0,1,0,0, 0,1,0,0,16'h0130));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0130));
`else
    vec.push_back(mk(0,0,0,1,0,0, 1,0,1,1,16'h0090));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,1,0,16'h0090));
`endif
    vec.push_back(mk(0,0,0,0,1,0, 1,0,0,0,16'h0000));
    // five keys then a non-digit code
    vec.push_back(mk(0,1,1,0,0,0, 1,0,1,0,16'h0001));
    vec.push_back(mk(0,1,2,0,0,0, 1,0,1,0,16'h0012));
    vec.push_back(mk(0,1,3,0,0,0, 1,0,1,0,16'h0123));
    vec.push_back(mk(0,1,4,0,0,0, 1,0,1,0,16'h1234));
    vec.push_back(mk(0,1,5,0,0,0, 1,0,1,0,16'h1234));
    vec.push_back(mk(0,1,12,0,0,0, 1,0,1,0,16'h1234));
    vec.push_back(mk(0,0,0,0,1,0, 1,0,0,0,16'h0000));
    // cancel beats key and start
    vec.push_back(mk(0,1,4,0,0,0, 1,0,1,0,16'h0004));
    vec.push_back(mk(0,1,2,0,0,0, 1,0,1,0,16'h0042));
    vec.push_back(mk(0,1,7,1,1,0, 1,0,0,0,16'h0000));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0000));
    // zero time in ENTRY and in IDLE
    vec.push_back(mk(0,1,0,0,0,0, 1,0,1,0,16'h0000));
    vec.push_back(mk(0,0,0,1,0,0, 1,0,1,0,16'h0000));
    vec.push_back(mk(0,0,0,0,1,0, 1,0,0,0,16'h0000));
    vec.push_back(mk(0,0,0,1,0,0, 1,0,0,0,16'h0000));
    // clear in LOAD
    vec.push_back(mk(0,1,5,0,0,0, 1,0,1,0,16'h0005));
    vec.push_back(mk(0,0,0,1,0,0, 0,1,0,0,16'h0005));
    vec.push_back(mk(1,0,0,0,0,0, 1,0,0,0,16'h0000));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0000));
    // clear mid-HOLD
    vec.push_back(mk(0,1,7,0,0,0, 1,0,1,0,16'h0007));
    vec.push_back(mk(0,0,0,1,0,0, 0,1,0,0,16'h0007));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0007));
    vec.push_back(mk(1,0,0,0,0,0, 1,0,0,0,16'h0000));
    vec.push_back(mk(0,0,0,0,0,1, 1,0,0,0,16'h0000));
    // start beats key; keys and start ignored in HOLD
    vec.push_back(mk(0,1,1,0,0,0, 1,0,1,0,16'h0001));
    vec.push_back(mk(0,1,2,1,0,0, 0,1,0,0,16'h0001));
    vec.push_back(mk(0,1,3,0,0,0, 1,0,0,0,16'h0001));
    vec.push_back(mk(0,0,0,1,0,0, 1,0,0,0,16'h0001));
    vec.push_back(mk(0,0,0,0,0,1, 1,0,0,0,16'h0000));
    // 00:59 is the largest seconds value accepted as-is
    vec.push_back(mk(0,1,5,0,0,0, 1,0,1,0,16'h0005));
    vec.push_back(mk(0,1,9,0,0,0, 1,0,1,0,16'h0059));
    vec.push_back(mk(0,0,0,1,0,0, 0,1,0,0,16'h0059));
    vec.push_back(mk(0,0,0,0,0,0, 1,0,0,0,16'h0059));
    vec.push_back(mk(0,0,0,0,1,0, 1,0,0,0,16'h0000));
    // non-digit in IDLE
    vec.push_back(mk(0,1,15,0,0,0, 1,0,0,0,16'h0000));

    drive(1, 0, 0, 0, 0, 0);
    foreach (vec[i]) begin
      drive(vec[i].clr, vec[i].kv, vec[i].kc,
            vec[i].st, vec[i].ca, vec[i].tz);
      check($sformatf("vec%0d", i), observed(), vec[i].exp);
    end

    // randomized run against the model
    begin
      bit clr, kv, st, ca, tz;
      bit [3:0] kc;
      drive(1, 0, 0, 0, 0, 0);
      model(1, 0, 0, 0, 0, 0);
      check("rnd_reset", observed(), model_out());
      for (int n = 0; n < 4000; n++) begin
        clr = ($urandom_range(0, 199) == 0);
        kv  = ($urandom_range(0, 9) < 4);
        kc  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                         : 4'($urandom_range(10, 15));
        if ($urandom_range(0, 3) == 0) kc = 4'd9;
        st  = ($urandom_range(0, 9) == 0);
        ca  = ($urandom_range(0, 29) == 0);
        tz  = ($urandom_range(0, 9) == 0);
        drive(clr, kv, kc, st, ca, tz);
        model(clr, kv, kc, st, ca, tz);
        check($sformatf("rnd%0d", n), observed(), model_out());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_entry_loader.md
# time_entry_loader

Keypad-side writer for the microwave countdown timer. Collects decimal key presses into an MM:SS value, validates it, and drives the parallel-load interface of the four-digit down-counter chain with a single load cycle on start. Sits between the keypad decoder and the timer counters, and holds off further entry while the timer runs.

## Interface
- `SEC_TENS_MAX`, 5: largest legal seconds-tens digit.
- `clock` in 1: rising-edge clock.
- `clear` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid.
- `key_code` in 4: 0–9 are digits; 10–15 are ignored.
- `start` in 1: one-cycle request to load the timer.
- `cancel` in 1: one-cycle request to abort entry or run.
- `timer_zero` in 1: AND of all counter `zero` flags.
- `loadn` out 1: active-low load to the counter chain.
- `load_enable` out 1: counter `enable` during the load cycle.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: counter `data_in` values and display digits.
- `entry_active` out 1: high in ENTRY.
- `entry_error` out 1: one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, ENTRY, LOAD, HOLD. All outputs are registered.
- IDLE or ENTRY, digit key: shift digits left, then go to ENTRY and increment `digit_cnt`.
  - `min_tens<=min_ones`, `min_ones<=sec_tens`, `sec_tens<=sec_ones`, `sec_ones<=key_code`.
  - `digit_cnt` saturates at 4; digit keys after the fourth are ignored.
- Non-digit codes are ignored in every state.
- ENTRY, `start`:
  - All digits 0: ignore; stay in ENTRY, no error.
  - `sec_tens > SEC_TENS_MAX`: see Configuration.
  - Otherwise go to LOAD.
- LOAD lasts exactly one cycle: `loadn=0`, `load_enable=1`, digits stable. Then go to HOLD.
- HOLD:
  - Keys and `start` are ignored.
  - Leave to IDLE when `timer_zero=1` or `cancel=1`. Clear digits and `digit_cnt` on exit.
- ENTRY, `cancel`: clear digits and `digit_cnt`; go to IDLE.
- `start` or `cancel` in IDLE: no effect.
- Simultaneous events in one cycle:
  - `clear` beats everything.
  - `cancel` beats `start` and key.
  - `start` beats key: the key is dropped, and start evaluates the pre-key digits.
- Reset values: state IDLE, all digits 0, `digit_cnt` 0, `loadn=1`, `load_enable=0`, `entry_active=0`, `entry_error=0`.
- `clear` in any state, including LOAD and HOLD: reset values on the next edge. A pending load is dropped.

## Timing
- Key strobe at edge N: new digits visible after edge N. `entry_active=1` from edge N.
- `start` at edge N: `loadn=0` and `load_enable=1` for the cycle after edge N only. The counters capture at edge N+1. State is HOLD after edge N+1.
- `timer_zero` is not examined until HOLD. The counters hold the loaded non-zero value from edge N+1, so there is no false exit.
- `entry_error` is high for exactly one cycle, following the rejecting `start` edge.
- `loadn` and `load_enable` never change outside LOAD.

## Configuration
- Macro `TIME_ENTRY_NORMALIZE_EN`.
- Defined: a start with seconds ≥ 60 is normalized in the LOAD cycle.
  - Seconds become seconds−60; minutes become minutes+1, in BCD.
  - Example: 00:90 loads as 01:30.
  - If minutes are already 99: reject with `entry_error`, stay in ENTRY, digits unchanged.
- Undefined: a start with `sec_tens > SEC_TENS_MAX` is rejected. `entry_error` pulses, state stays ENTRY, digits are unchanged.

## Test plan
- Keys 1,3,0 then `start`:
  - Digits read 0,1,3,0 after the keys.
  - `loadn` is low for exactly one cycle with 01:30, then HOLD.
  - `timer_zero=1` → IDLE with digits 0.
- Keys 9,0 then `start`:
  - Without macro: `entry_error` one-cycle pulse, digits stay 00:90, state ENTRY.
  - With macro: load 01:30.
- Keys 1,2,3,4,5, then code 12: digits 12:34, `digit_cnt=4`.
- Keys 4,2 then `cancel` asserted together with key 7 and `start`: IDLE, digits 0, no `loadn` pulse.
- `start` with digits 00:00 in ENTRY: no load, no error.
- `start` with digits 00:00 in IDLE: no load, no error.
- `clear` asserted in the LOAD cycle and mid-HOLD: next cycle all outputs at reset values, `loadn=1`.
